// File: rtl/alu_seq_if.sv
// alu_seq_if: command/response handshake bundle between a requester and alu_seq.
//   cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b : command channel (requester -> sequencer)
//   rsp_valid/rsp_ready/rsp_result/rsp_carry/rsp_zero/rsp_err : response channel
// Modports: master = requester side, slave = sequencer side.
interface alu_seq_if #(
   parameter int unsigned W = 16
) ();
   logic           cmd_valid;
   logic           cmd_ready;
   logic [2:0]     cmd_op;
   logic [W-1:0]   cmd_a;
   logic [W-1:0]   cmd_b;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [2*W-1:0] rsp_result;
   logic           rsp_carry;
   logic           rsp_zero;
   logic           rsp_err;

   modport master (
      output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
      input  cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
   );

   modport slave (
      input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
      output cmd_ready, rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err
   );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: sequencer that owns an external W-bit ALU and runs ADD/SUB/AND/OR/XOR in one
// execute cycle and an unsigned 16x16->32 shift-add multiply (W iterations on the ALU adder).
// Ports:
//   clk, rst_n          : clock (rising edge), asynchronous active-low reset
//   bus (slave)         : command/response handshake, see alu_seq_if
//   alu_a, alu_b        : ALU operands
//   alu_ci..alu_no      : ALU control bits (carry-in, negate-b, inhibit-carry, zero-b,
//                         negate-a, xor-generate, negate-output)
//   alu_out, alu_co     : ALU result and carry-out
// Optional feature: define ALU_SEQ_SIGNED_MUL_EN to build op 6 (MULS), a two's-complement
// multiply implemented as the unsigned multiply plus two correction cycles. Without the
// macro op 6 is reported as an illegal opcode.
module alu_seq #(
   parameter int unsigned W = 16
) (
   input  logic         clk,
   input  logic         rst_n,
   alu_seq_if.slave     bus,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic         alu_ci,
   output logic         alu_nb,
   output logic         alu_ic,
   output logic         alu_zb,
   output logic         alu_na,
   output logic         alu_xo,
   output logic         alu_no,
   input  logic [W-1:0] alu_out,
   input  logic         alu_co
);

   localparam int unsigned CntW = (W > 1) ? $clog2(W) : 1;

   localparam logic [2:0] OpAdd  = 3'd0;
   localparam logic [2:0] OpSub  = 3'd1;
   localparam logic [2:0] OpAnd  = 3'd2;
   localparam logic [2:0] OpOr   = 3'd3;
   localparam logic [2:0] OpXor  = 3'd4;
   localparam logic [2:0] OpMul  = 3'd5;
`ifdef ALU_SEQ_SIGNED_MUL_EN
   localparam logic [2:0] OpMuls = 3'd6;
`endif

   typedef enum logic [2:0] {
      StIdle,
      StExec,
      StMul,
`ifdef ALU_SEQ_SIGNED_MUL_EN
      StCorr1,
      StCorr2,
`endif
      StDone
   } state_e;

   state_e         state_q, state_d;
   logic [2:0]     op_q, op_d;
   logic [W-1:0]   a_q, a_d;
   logic [W-1:0]   b_q, b_d;
   // Product / result register; single-cycle ops land in p_lo with p_hi = 0.
   logic [W-1:0]   p_hi_q, p_hi_d;
   logic [W-1:0]   p_lo_q, p_lo_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic           carry_q, carry_d;
   logic           err_q, err_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
         op_q    <= '0;
         a_q     <= '0;
         b_q     <= '0;
         p_hi_q  <= '0;
         p_lo_q  <= '0;
         cnt_q   <= '0;
         carry_q <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         a_q     <= a_d;
         b_q     <= b_d;
         p_hi_q  <= p_hi_d;
         p_lo_q  <= p_lo_d;
         cnt_q   <= cnt_d;
         carry_q <= carry_d;
         err_q   <= err_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      op_d          = op_q;
      a_d           = a_q;
      b_d           = b_q;
      p_hi_d        = p_hi_q;
      p_lo_d        = p_lo_q;
      cnt_d         = cnt_q;
      carry_d       = carry_q;
      err_d         = err_q;
      bus.cmd_ready = 1'b0;
      alu_a         = '0;
      alu_b         = '0;
      alu_ci        = 1'b0;
      alu_nb        = 1'b0;
      alu_ic        = 1'b0;
      alu_zb        = 1'b0;
      alu_na        = 1'b0;
      alu_xo        = 1'b0;
      alu_no        = 1'b0;

      unique case (state_q)
         StIdle: begin
            bus.cmd_ready = 1'b1;
            if (bus.cmd_valid) begin
               op_d    = bus.cmd_op;
               a_d     = bus.cmd_a;
               b_d     = bus.cmd_b;
               carry_d = 1'b0;
               err_d   = 1'b0;
               cnt_d   = '0;
               case (bus.cmd_op)
                  OpAdd, OpSub, OpAnd, OpOr, OpXor: state_d = StExec;
`ifdef ALU_SEQ_SIGNED_MUL_EN
                  OpMul, OpMuls: begin
`else
                  OpMul: begin
`endif
                     p_hi_d  = '0;
                     p_lo_d  = bus.cmd_b;
                     state_d = StMul;
                  end
                  default: begin
                     p_hi_d  = '0;
                     p_lo_d  = '0;
                     err_d   = 1'b1;
                     state_d = StDone;
                  end
               endcase
            end
         end

         StExec: begin
            alu_a = a_q;
            alu_b = b_q;
            case (op_q)
               OpSub: begin
                  alu_nb = 1'b1;
                  alu_ci = 1'b1;
               end
               OpAnd: begin
                  // ~(~a | ~b) built from the OR path
                  alu_na = 1'b1;
                  alu_nb = 1'b1;
                  alu_ic = 1'b1;
                  alu_xo = 1'b1;
                  alu_no = 1'b1;
               end
               OpOr: begin
                  alu_ic = 1'b1;
                  alu_xo = 1'b1;
               end
               OpXor: alu_ic = 1'b1;
               default: ;
            endcase
            p_hi_d  = '0;
            p_lo_d  = alu_out;
            carry_d = (op_q == OpAdd || op_q == OpSub) ? alu_co : 1'b0;
            state_d = StDone;
         end

         StMul: begin
            // Conditional add of A into the upper half: zero B when the multiplier bit is 0.
            alu_a  = p_hi_q;
            alu_b  = a_q;
            alu_zb = ~p_lo_q[0];
            {p_hi_d, p_lo_d} = {alu_co, alu_out, p_lo_q[W-1:1]};
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == CntW'(W - 1)) begin
`ifdef ALU_SEQ_SIGNED_MUL_EN
               state_d = (op_q == OpMuls) ? StCorr1 : StDone;
`else
               state_d = StDone;
`endif
            end
         end

`ifdef ALU_SEQ_SIGNED_MUL_EN
         // Two's-complement fix-up: subtract B<<W if A<0, then A<<W if B<0.
         StCorr1: begin
            alu_a = p_hi_q;
            alu_b = b_q;
            if (a_q[W-1]) begin
               alu_nb = 1'b1;
               alu_ci = 1'b1;
            end else begin
               alu_zb = 1'b1;
            end
            p_hi_d  = alu_out;
            state_d = StCorr2;
         end

         StCorr2: begin
            alu_a = p_hi_q;
            alu_b = a_q;
            if (b_q[W-1]) begin
               alu_nb = 1'b1;
               alu_ci = 1'b1;
            end else begin
               alu_zb = 1'b1;
            end
            p_hi_d  = alu_out;
            state_d = StDone;
         end
`endif

         StDone: begin
            if (bus.rsp_ready) state_d = StIdle;
         end

         default: state_d = StIdle;
      endcase
   end

   assign bus.rsp_valid  = (state_q == StDone);
   assign bus.rsp_result = {p_hi_q, p_lo_q};
   assign bus.rsp_carry  = carry_q;
   assign bus.rsp_err    = err_q;
   // Gated so the flag reads 0 out of reset, when no response is pending.
   assign bus.rsp_zero   = (state_q == StDone) && ({p_hi_q, p_lo_q} == '0);

endmodule

// File: tb/tb_alu_seq.sv
module tb_alu_seq;
   localparam int unsigned W = 16;

   logic clk;
   logic rst_n;
   logic [W-1:0] alu_a, alu_b, alu_out;
   logic alu_ci, alu_nb, alu_ic, alu_zb, alu_na, alu_xo, alu_no, alu_co;

   alu_seq_if #(.W(W)) bus ();

   alu_seq #(.W(W)) dut (
      .clk    (clk),
      .rst_n  (rst_n),
      .bus    (bus.slave),
      .alu_a  (alu_a),
      .alu_b  (alu_b),
      .alu_ci (alu_ci),
      .alu_nb (alu_nb),
      .alu_ic (alu_ic),
      .alu_zb (alu_zb),
      .alu_na (alu_na),
      .alu_xo (alu_xo),
      .alu_no (alu_no),
      .alu_out(alu_out),
      .alu_co (alu_co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural model of the external ALU.
   logic [W-1:0] m_a, m_b0, m_b1, m_r;
   logic [W:0]   m_sum;
   always_comb begin
      m_a   = alu_na ? ~alu_a : alu_a;
      m_b0  = alu_zb ? '0 : alu_b;
      m_b1  = alu_nb ? ~m_b0 : m_b0;
      m_sum = {1'b0, m_a} + {1'b0, m_b1} + {{W{1'b0}}, alu_ci};
      if (alu_ic) begin
         m_r    = (m_a ^ m_b1) ^ (alu_xo ? (m_a & m_b1) : '0);
         alu_co = 1'b0;
      end else begin
         m_r    = m_sum[W-1:0];
         alu_co = m_sum[W];
      end
      alu_out = alu_no ? ~m_r : m_r;
   end

   int total = 0;
   int bad   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s got=%0h want=%0h", name, act, exp);
      end
   endtask

   task automatic chk_quiet_outputs(input string tag);
      chk({tag, "_rsp_valid"}, bus.rsp_valid, 0);
      chk({tag, "_rsp_result"}, bus.rsp_result, 0);
      chk({tag, "_rsp_carry"}, bus.rsp_carry, 0);
      chk({tag, "_rsp_zero"}, bus.rsp_zero, 0);
      chk({tag, "_rsp_err"}, bus.rsp_err, 0);
      chk({tag, "_alu_ab"}, {alu_a, alu_b}, 0);
      chk({tag, "_alu_ctl"}, {alu_ci, alu_nb, alu_ic, alu_zb, alu_na, alu_xo, alu_no}, 0);
      chk({tag, "_cmd_ready"}, bus.cmd_ready, 1);
   endtask

   task automatic run_cmd(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [2*W-1:0] res, output logic car, output logic zer,
                          output logic er, output int lat);
      int guard;
      @(negedge clk);
      guard = 0;
      while (!bus.cmd_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      chk("ready_before_cmd", bus.cmd_ready, 1);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = op;
      bus.cmd_a     = a;
      bus.cmd_b     = b;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      lat = 1;
      while (!bus.rsp_valid && lat < 40) begin
         @(posedge clk);
         #1;
         lat++;
      end
      res = bus.rsp_result;
      car = bus.rsp_carry;
      zer = bus.rsp_zero;
      er  = bus.rsp_err;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      chk("idle_after_rsp_ready", bus.cmd_ready, 1);
      chk("idle_after_rsp_valid", bus.rsp_valid, 0);
   endtask

   typedef struct {
      logic [2:0]     op;
      logic [W-1:0]   a;
      logic [W-1:0]   b;
      logic [2*W-1:0] res;
      logic           carry;
      logic           zero;
      logic           err;
      int             lat;
   } vec_t;

   vec_t vecs[12];

   initial begin
      logic [2*W-1:0] r;
      logic c, z, e;
      int lat;
      int seen;

      vecs[0]  = '{3'd0, 16'h1234, 16'hEDCC, 32'h0000_0000, 1'b1, 1'b1, 1'b0, 2};
      vecs[1]  = '{3'd1, 16'h0005, 16'h0007, 32'h0000_FFFE, 1'b0, 1'b0, 1'b0, 2};
      vecs[2]  = '{3'd2, 16'hF0F0, 16'h3C3C, 32'h0000_3030, 1'b0, 1'b0, 1'b0, 2};
      vecs[3]  = '{3'd3, 16'hF0F0, 16'h3C3C, 32'h0000_FCFC, 1'b0, 1'b0, 1'b0, 2};
      vecs[4]  = '{3'd4, 16'hF0F0, 16'h3C3C, 32'h0000_CCCC, 1'b0, 1'b0, 1'b0, 2};
      vecs[5]  = '{3'd5, 16'hFFFF, 16'hFFFF, 32'hFFFE_0001, 1'b0, 1'b0, 1'b0, 17};
      vecs[6]  = '{3'd5, 16'h0000, 16'h1234, 32'h0000_0000, 1'b0, 1'b1, 1'b0, 17};
`ifdef ALU_SEQ_SIGNED_MUL_EN
      vecs[7]  = '{3'd6, 16'hFFFF, 16'h0002, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 19};
`else
      vecs[7]  = '{3'd6, 16'hFFFF, 16'h0002, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1};
`endif
      vecs[8]  = '{3'd7, 16'h1111, 16'h2222, 32'h0000_0000, 1'b0, 1'b1, 1'b1, 1};
      vecs[9]  = '{3'd0, 16'hFFFF, 16'h0002, 32'h0000_0001, 1'b1, 1'b0, 1'b0, 2};
      vecs[10] = '{3'd1, 16'h0007, 16'h0005, 32'h0000_0002, 1'b1, 1'b0, 1'b0, 2};
      vecs[11] = '{3'd5, 16'h1234, 16'h5678, 32'h0626_0060, 1'b0, 1'b0, 1'b0, 17};

      bus.cmd_valid = 1'b0;
      bus.cmd_op    = '0;
      bus.cmd_a     = '0;
      bus.cmd_b     = '0;
      bus.rsp_ready = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 chk_quiet_outputs("reset");
      @(negedge clk);
      rst_n = 1'b1;

      // Vector table.
      for (int i = 0; i < 12; i++) begin
         run_cmd(vecs[i].op, vecs[i].a, vecs[i].b, r, c, z, e, lat);
         chk($sformatf("v%0d_result", i), r, vecs[i].res);
         chk($sformatf("v%0d_carry", i), c, vecs[i].carry);
         chk($sformatf("v%0d_zero", i), z, vecs[i].zero);
         chk($sformatf("v%0d_err", i), e, vecs[i].err);
         chk($sformatf("v%0d_latency", i), lat, vecs[i].lat);
      end

      // Response held in DONE while rsp_ready is low; new commands ignored.
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd0;
      bus.cmd_a     = 16'h0001;
      bus.cmd_b     = 16'h0002;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      seen = 0;
      while (!bus.rsp_valid && seen < 40) begin
         @(posedge clk);
         #1 seen++;
      end
      chk("hold_rsp_arrived", bus.rsp_valid, 1);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b1;
         bus.cmd_op    = 3'd4;
         bus.cmd_a     = 16'hAAAA;
         bus.cmd_b     = 16'h5555;
         #1;
         chk($sformatf("hold%0d_valid", k), bus.rsp_valid, 1);
         chk($sformatf("hold%0d_result", k), bus.rsp_result, 32'h0000_0003);
         chk($sformatf("hold%0d_flags", k), {bus.rsp_carry, bus.rsp_zero, bus.rsp_err}, 3'b000);
         chk($sformatf("hold%0d_cmd_ready", k), bus.cmd_ready, 0);
      end
      @(negedge clk);
      bus.cmd_valid = 1'b0;
      bus.rsp_ready = 1'b1;
      @(posedge clk);
      #1 bus.rsp_ready = 1'b0;
      chk("hold_release_ready", bus.cmd_ready, 1);
      chk("hold_release_valid", bus.rsp_valid, 0);
      run_cmd(3'd4, 16'hF0F0, 16'h3C3C, r, c, z, e, lat);
      chk("after_hold_result", r, 32'h0000_CCCC);
      chk("after_hold_latency", lat, 2);

      // Reset asserted during MUL iteration 7 aborts the operation.
      @(negedge clk);
      bus.cmd_valid = 1'b1;
      bus.cmd_op    = 3'd5;
      bus.cmd_a     = 16'h1234;
      bus.cmd_b     = 16'h5678;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1 chk_quiet_outputs("midmul_reset");
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int k = 0; k < 25; k++) begin
         @(negedge clk);
         if (bus.rsp_valid) seen++;
      end
      chk("no_rsp_after_abort", seen, 0);
      chk("ready_after_abort", bus.cmd_ready, 1);
      run_cmd(3'd0, 16'h1234, 16'hEDCC, r, c, z, e, lat);
      chk("post_abort_add_result", r, 32'h0000_0000);
      chk("post_abort_add_carry", c, 1);
      chk("post_abort_add_zero", z, 1);
      chk("post_abort_add_latency", lat, 2);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running want=finished");
      $fatal(1, "timeout");
   end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Sequencer that owns the shared 16-bit ALU datapath and drives its operands and control bits (ci, nb, ic, zb, na, xo, no) from a command/response handshake.
- Runs single-cycle ops (ADD, SUB, AND, OR, XOR) and a multi-cycle 16x16->32 unsigned shift-add multiply that reuses the ALU adder on every iteration.
- The ALU is instantiated outside this block. This block only connects to its ports.

Parameters:
- W, 16, datapath width; the multiply iteration count equals W.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block can accept a command
- cmd_op  in  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 MUL, 6 MULS (optional), 7 reserved
- cmd_a  in  W  operand A
- cmd_b  in  W  operand B
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts the result
- rsp_result  out  2W  result; upper W bits are 0 for non-multiply ops
- rsp_carry  out  1  ALU carry-out for ADD/SUB, else 0
- rsp_zero  out  1  rsp_result == 0
- rsp_err  out  1  illegal opcode
- alu_a, alu_b  out  W  ALU operands
- alu_ci, alu_nb, alu_ic, alu_zb, alu_na, alu_xo, alu_no  out  1  ALU control bits
- alu_out  in  W  ALU result
- alu_co  in  1  ALU carry-out

Behaviour:
- Reset (async assert, sync deassert): state IDLE, cmd_ready=1, rsp_valid=0, all rsp_* = 0, all alu_* = 0. Assertion mid-operation aborts it immediately; no response is produced.
- ALU control encodings (all bits not listed are 0):
  - ADD: all 0.
  - SUB: nb=1, ci=1.
  - OR: ic=1, xo=1.
  - AND: na=1, nb=1, ic=1, xo=1, no=1.
  - XOR: ic=1.
  - PASS-A: zb=1.
- States: IDLE, EXEC, MUL, CORR1, CORR2, DONE.
- IDLE:
  - cmd_ready=1.
  - On cmd_valid, latch op/a/b. Ops 0-4 go to EXEC; op 5 goes to MUL.
  - Op 6 goes to MUL when the macro is defined; otherwise it goes straight to DONE with err=1 and result 0.
  - Op 7 goes to DONE with err=1 and result 0.
- EXEC (1 cycle):
  - Drive alu_a=A, alu_b=B and the op encoding.
  - Register result={0,alu_out}. carry=alu_co for ADD/SUB, 0 otherwise.
  - Go to DONE.
- MUL (W cycles, counter 0..W-1):
  - Registers are P_hi=0 and P_lo=B at entry.
  - Each cycle: alu_a=P_hi, alu_b=A, ADD encoding with zb=~P_lo[0].
  - Update {P_hi,P_lo} <= {alu_co, alu_out, P_lo} >> 1.
  - After the cycle with counter W-1: op 5 goes to DONE; op 6 goes to CORR1.
  - Carry flag is 0.
- DONE:
  - rsp_valid=1. Outputs are held stable until rsp_ready.
  - On rsp_valid & rsp_ready, go to IDLE.
  - cmd_ready=0 in every state except IDLE, so there is no back-to-back accept in the same cycle as the response handshake.
- Latency, counted from the accept edge:
  - ALU ops: rsp_valid rises 2 edges later.
  - MUL: rsp_valid rises W+1 edges later.
  - Illegal op: rsp_valid rises 1 edge later.
- Carry convention: for SUB, carry=1 means no borrow.
- rsp_zero covers the full 2W bits.

Optional Feature:
- Macro: ALU_SEQ_SIGNED_MUL_EN. When defined, op 6 (MULS) is a two's-complement multiply: the unsigned multiply followed by two correction cycles.
  - CORR1: alu_a=P_hi, alu_b=B. Use SUB if A[W-1]=1, else PASS-A. P_hi <= alu_out.
  - CORR2: alu_a=P_hi, alu_b=A. Use SUB if B[W-1]=1, else PASS-A. P_hi <= alu_out. Go to DONE.
  - MULS latency is W+3 edges.
- When undefined: CORR states are not built; op 6 returns err=1, result 0 with illegal-op latency.

Test Plan:
- ADD a=0x1234, b=0xEDCC -> result 0x00000000, carry=1, zero=1, err=0, rsp_valid 2 edges after accept.
- SUB a=0x0005, b=0x0007 -> result 0x0000FFFE, carry=0, zero=0. AND 0xF0F0,0x3C3C -> 0x00003030. OR of the same operands -> 0x0000FCFC. XOR of the same operands -> 0x0000CCCC.
- MUL a=0xFFFF, b=0xFFFF -> result 0xFFFE0001 after W+1 edges; MUL a=0x0000, b=0x1234 -> 0x00000000, zero=1.
- MULS a=0xFFFF, b=0x0002:
  - Macro on: result 0xFFFFFFFE after W+3 edges.
  - Macro off: err=1, result 0.
  - Op 7 always gives err=1.
- Hold rsp_ready=0 for 5 cycles in DONE: rsp_* stay stable, cmd_ready=0, a new cmd_valid is ignored. Raise rsp_ready: return to IDLE, then the next command is accepted.
- Assert rst_n=0 at MUL iteration 7: all outputs 0 immediately. After release, cmd_ready=1 and no response is produced. A fresh ADD then completes normally.
